channel_serializer: RTL and testbench
=====================================

# channel_serializer

Width-converting stage for valid/data-acknowledge channels. It accepts one NIn-bit word on its input channel and emits it as K = NIn/NOut consecutive NOut-bit beats on its output channel. It sits between a wide producer (e.g. a ChannelSender-driven word source) and a narrow link or consumer. With a continuously acknowledging sink it sustains full rate: one beat per clock, with no bubble between words.

## Interface
Parameters:
- NIn, 16: input word width; must be an integer multiple of NOut, otherwise elaboration fails ($error).
- NOut, 4: output beat width; K = NIn/NOut beats per word; K = 1 is legal (registered pass-through).
- MSBFirst, 0: 0 = least-significant beat first; 1 = most-significant beat first.

Ports:
- clk  input  1  sole clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low; 0 = in reset.
- in.d  input  NIn  input word.
- in.v  input  1  input valid, driven by upstream from posedge.
- in.a  output  1  input acknowledge, combinational.
- out.d  output  NOut  current beat, driven from register.
- out.v  output  1  output valid, driven from register.
- out.a  input  1  output acknowledge from downstream, combinational.

## Operation
- Handshake rule on both channels: a transfer occurs at a posedge where v = 1 and a = 1. A sender holds v and d stable until that transfer.
- State: EMPTY, or SENDING with beat counter cnt in 0..K-1, width max(1, $clog2(K)). Holding register sr is NIn bits.
- EMPTY: in.a = 1 (except in reset); out.v = 0. On input transfer, load sr from in.d, set cnt = 0, go to SENDING.
- SENDING: out.v = 1. out.d = sr[NOut-1:0] if MSBFirst = 0, else sr[NIn-1:NIn-NOut].
- On an output transfer with cnt < K-1: shift sr by NOut toward the emitted end and increment cnt.
- On an output transfer with cnt = K-1 (last beat):
  - if in.v = 1, take the input transfer on the same edge, reload sr, set cnt = 0, stay in SENDING;
  - otherwise go to EMPTY.
- in.a = EMPTY || (SENDING && cnt = K-1 && out.a). This is a deliberate combinational path out.a -> in.a; downstream must not derive out.a from in.a.
- in.a = 0 while reset = 0.
- No output transfer (out.a = 0): sr, cnt and out.d hold; out.v stays 1. A beat is never dropped or repeated.
- Data in sr is passed bit-exact; no arithmetic on it. Vacated sr bits fill with 0.

## Timing
- Reset values (asserted asynchronously and held while reset = 0): state EMPTY, cnt = 0, sr = 0, out.v = 0, out.d = 0, in.a = 0.
- First edge after reset release: in.a = 1, since the block is EMPTY.
- Latency: word accepted at edge t; beat 0 is valid on out.d in the cycle following t.
- Sustained throughput with out.a = 1 and in.v = 1: one beat per cycle, with no idle cycle between words. in.a is high only in the cycle of each last beat.
- With K = 1, in.a = EMPTY || out.a: a one-entry pipeline register sustaining one word per cycle.
- Reset asserted mid-word: the held word is discarded and out.v falls immediately. After release, the next accepted word starts at beat 0.
- in.v asserted while SENDING and cnt < K-1: in.a = 0, and upstream holds its word.

## Test plan
- Reset: hold reset = 0 for 3 cycles with in.v = 1 -> out.v = 0, out.d = 0, in.a = 0. After release, in.a = 1 and the first word is accepted on the next edge.
- Single word (NIn = 16, NOut = 4): in.d = 16'hABCD, out.a held 1 -> beats D, C, B, A on 4 consecutive cycles, then out.v = 0. in.a = 0 during beats D, C, B.
- Back-to-back: 16'h1234 then 16'h5678, in.v held, out.a = 1 -> 8 consecutive beats 4, 3, 2, 1, 8, 7, 6, 5 with no gap. Second word accepted on the edge ending beat 1.
- Backpressure: out.a = 0 for 3 cycles while beat C of 16'hABCD is presented -> out.d = C and out.v = 1 stable throughout; then B, A follow.
- Mid-word reset: assert reset after beat D of 16'hABCD -> out.v = 0 asynchronously. Release, then send 16'h00F1 -> beats 1, F, 0, 0.
- MSBFirst = 1, in.d = 16'hABCD -> beats A, B, C, D.
- K = 1 (NIn = NOut = 8): 10 words with random in.v and out.a -> output sequence equals input sequence, one transfer per cycle when both sides are ready.

Source files
------------

// File: rtl/channel_serializer.sv
// rtl/channel_serializer.sv - splits one NIn-bit input word into NIn/NOut output beats
// Beats are emitted from the low end of sr (or high end when MSBFirst) and sr shifts toward it.
module channel_serializer #(
  parameter int NIn      = 16,
  parameter int NOut     = 4,
  parameter int MSBFirst = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIn-1:0]  in_d,
  input  logic            in_v,
  output logic            in_a,
  output logic [NOut-1:0] out_d,
  output logic            out_v,
  input  logic            out_a
);

  localparam int K  = NIn / NOut;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  generate
    if (NIn % NOut != 0) begin : g_bad_width
      $error("channel_serializer: NIn must be a multiple of NOut");
    end
  endgenerate

  typedef enum logic {EMPTY, SENDING} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NIn-1:0]  sr_q, sr_d;
  logic [NIn-1:0]  sr_shifted;
  logic            last_beat;
  logic            in_fire;
  logic            out_fire;

  generate
    if (K == 1) begin : g_no_shift
      assign sr_shifted = '0;
    end else if (MSBFirst != 0) begin : g_shift_up
      assign sr_shifted = {sr_q[NIn-NOut-1:0], {NOut{1'b0}}};
    end else begin : g_shift_down
      assign sr_shifted = {{NOut{1'b0}}, sr_q[NIn-1:NOut]};
    end

    if (MSBFirst != 0) begin : g_out_msb
      assign out_d = sr_q[NIn-1:NIn-NOut];
    end else begin : g_out_lsb
      assign out_d = sr_q[NOut-1:0];
    end
  endgenerate

  assign last_beat = (cnt_q == CW'(K - 1));
  assign out_v     = (state_q == SENDING);
  // out_a feeds in_a combinationally so a new word can load on the last-beat edge.
  assign in_a      = reset && ((state_q == EMPTY) || (last_beat && out_a));
  assign in_fire   = in_v && in_a;
  assign out_fire  = out_v && out_a;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    if (state_q == EMPTY) begin
      if (in_fire) begin
        state_d = SENDING;
        cnt_d   = '0;
        sr_d    = in_d;
      end
    end else if (out_fire) begin
      if (!last_beat) begin
        cnt_d = cnt_q + CW'(1);
        sr_d  = sr_shifted;
      end else if (in_fire) begin
        cnt_d = '0;
        sr_d  = in_d;
      end else begin
        state_d = EMPTY;
        cnt_d   = '0;
        sr_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

endmodule

// File: tb/tb_channel_serializer.sv
// tb/tb_channel_serializer.sv - directed bench for channel_serializer (LSB-first, MSB-first, K=1)
module tb_channel_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] a_in_d;  logic a_in_v, a_in_a;  logic [3:0] a_out_d;  logic a_out_v, a_out_a;
  logic [15:0] b_in_d;  logic b_in_v, b_in_a;  logic [3:0] b_out_d;  logic b_out_v, b_out_a;
  logic [7:0]  c_in_d;  logic c_in_v, c_in_a;  logic [7:0] c_out_d;  logic c_out_v, c_out_a;

  channel_serializer #(.NIn(16), .NOut(4), .MSBFirst(0)) dut_a (
    .clk(clk), .reset(reset), .in_d(a_in_d), .in_v(a_in_v), .in_a(a_in_a),
    .out_d(a_out_d), .out_v(a_out_v), .out_a(a_out_a));
  channel_serializer #(.NIn(16), .NOut(4), .MSBFirst(1)) dut_b (
    .clk(clk), .reset(reset), .in_d(b_in_d), .in_v(b_in_v), .in_a(b_in_a),
    .out_d(b_out_d), .out_v(b_out_v), .out_a(b_out_a));
  channel_serializer #(.NIn(8), .NOut(8), .MSBFirst(0)) dut_c (
    .clk(clk), .reset(reset), .in_d(c_in_d), .in_v(c_in_v), .in_a(c_in_a),
    .out_d(c_out_d), .out_v(c_out_v), .out_a(c_out_a));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input string tag, input logic [3:0] d, input logic a);
    step();
    chk({tag, "_v"}, a_out_v, 1);
    chk({tag, "_d"}, a_out_d, d);
    chk({tag, "_ina"}, a_in_a, a);
  endtask

  logic [3:0] b2b_exp [8];
  logic [7:0] c_words [10];
  logic [7:0] c_q [$];
  int c_sent, c_recv, c_cyc;
  logic [7:0] c_exp;

  initial begin
    b2b_exp = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
    c_words = '{8'h3C, 8'hA5, 8'h00, 8'hFF, 8'h12, 8'h81, 8'h7E, 8'h55, 8'hC3, 8'h09};

    // Reset held with in_v high
    reset = 1'b0;
    a_in_d = 16'hABCD; a_in_v = 1'b1; a_out_a = 1'b1;
    b_in_d = 16'h0;    b_in_v = 1'b0; b_out_a = 1'b1;
    c_in_d = 8'h0;     c_in_v = 1'b0; c_out_a = 1'b0;
    repeat (3) step();
    chk("rst_out_v", a_out_v, 0);
    chk("rst_out_d", a_out_d, 0);
    chk("rst_in_a", a_in_a, 0);
    chk("rst_b_out_v", b_out_v, 0);
    chk("rst_c_out_v", c_out_v, 0);

    // Release: in_a rises at once, word accepted on next edge
    reset = 1'b1;
    #1;
    chk("rel_in_a", a_in_a, 1);
    beat_a("single_b0", 4'hD, 0);
    a_in_v = 1'b0;
    beat_a("single_b1", 4'hC, 0);
    beat_a("single_b2", 4'hB, 0);
    beat_a("single_b3", 4'hA, 1);
    step();
    chk("single_end_v", a_out_v, 0);
    chk("single_end_ina", a_in_a, 1);

    // Back-to-back words with in_v held
    a_in_d = 16'h1234; a_in_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat_a($sformatf("b2b_%0d", i), b2b_exp[i], (i == 3 || i == 7));
      if (i == 0) a_in_d = 16'h5678;
      if (i == 4) a_in_v = 1'b0;
    end
    step();
    chk("b2b_end_v", a_out_v, 0);

    // Backpressure on beat C, with a new word waiting upstream
    a_in_d = 16'hABCD; a_in_v = 1'b1;
    beat_a("bp_b0", 4'hD, 0);
    a_in_v = 1'b0;
    beat_a("bp_b1", 4'hC, 0);
    a_out_a = 1'b0; a_in_d = 16'hFFFF; a_in_v = 1'b1;
    #1;
    chk("bp_wait_ina", a_in_a, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold_v_%0d", i), a_out_v, 1);
      chk($sformatf("bp_hold_d_%0d", i), a_out_d, 4'hC);
      chk($sformatf("bp_hold_ina_%0d", i), a_in_a, 0);
    end
    a_out_a = 1'b1;
    beat_a("bp_b2", 4'hB, 0);
    beat_a("bp_b3", 4'hA, 1);
    beat_a("bp_f0", 4'hF, 0);
    a_in_v = 1'b0;
    beat_a("bp_f1", 4'hF, 0);
    beat_a("bp_f2", 4'hF, 0);
    beat_a("bp_f3", 4'hF, 1);
    step();
    chk("bp_end_v", a_out_v, 0);

    // Mid-word reset drops the word asynchronously
    a_in_d = 16'hABCD; a_in_v = 1'b1;
    beat_a("mid_b0", 4'hD, 0);
    a_in_v = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_async_v", a_out_v, 0);
    chk("mid_async_ina", a_in_a, 0);
    chk("mid_async_d", a_out_d, 0);
    step();
    reset = 1'b1;
    a_in_d = 16'h00F1; a_in_v = 1'b1;
    beat_a("mid_n0", 4'h1, 0);
    a_in_v = 1'b0;
    beat_a("mid_n1", 4'hF, 0);
    beat_a("mid_n2", 4'h0, 0);
    beat_a("mid_n3", 4'h0, 1);
    step();
    chk("mid_end_v", a_out_v, 0);

    // MSB-first instance
    b_in_d = 16'hABCD; b_in_v = 1'b1;
    step();
    b_in_v = 1'b0;
    chk("msb_b0", b_out_d, 4'hA);
    step(); chk("msb_b1", b_out_d, 4'hB);
    step(); chk("msb_b2", b_out_d, 4'hC);
    step(); chk("msb_b3", b_out_d, 4'hD);
    chk("msb_b3_v", b_out_v, 1);
    step(); chk("msb_end_v", b_out_v, 0);

    // K = 1 pipeline register with random handshakes
    c_sent = 0; c_recv = 0; c_cyc = 0;
    c_in_v = 1'b0;
    while (c_recv < 10 && c_cyc < 300) begin
      if (!c_in_v && c_sent < 10 && $urandom_range(0, 3) != 0) begin
        c_in_v = 1'b1;
        c_in_d = c_words[c_sent];
      end
      c_out_a = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      assert (c_in_a === (!c_out_v || c_out_a)) else begin
        errors++;
        $error("FAIL k1_in_a observed %b expected %b", c_in_a, (!c_out_v || c_out_a));
      end
      if (c_out_v && c_out_a) begin
        if (c_q.size() == 0) begin
          chk("k1_spurious", 1, 0);
        end else begin
          c_exp = c_q.pop_front();
          chk($sformatf("k1_word_%0d", c_recv), c_out_d, c_exp);
        end
        c_recv++;
      end
      if (c_in_v && c_in_a) begin
        c_q.push_back(c_in_d);
        c_sent++;
      end
      step();
      if (c_in_v && c_q.size() > 0 && c_q[c_q.size()-1] === c_in_d && c_sent > 0
          && c_words[c_sent-1] === c_in_d)
        c_in_v = 1'b0;
      c_cyc++;
    end
    chk("k1_all_received", c_recv, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
